simdnx_round_sat: RTL

Parametrised N-channel SIMD rounding/saturation stage: right-shifts each signed accumulator lane by a runtime amount, rounds by a selectable mode, saturates to the output width, and flags clipped lanes. It sits between the bicubic MAC array and the pixel packer. It is the successor of the fixed two-channel, fixed-shift, half-up rounding stage, adding:

- a valid/ready stream interface with back-pressure;
- per-beat shift and mode selection;
- saturation reporting with a sticky counter.

---
 rtl/simdnx_round_sat.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/simdnx_round_sat.sv
`default_nettype none
// ============================================================================
//  Module   : simdnx_round_sat
//  Purpose  : N-lane SIMD stage that arithmetic-right-shifts each signed
//             accumulator lane by a per-beat amount, rounds (half-up,
//             truncate or half-even), saturates to OUTPUT_WIDTH and reports
//             clipped lanes plus a sticky count of saturating beats.
//             Three register stages with a single global stall enable.
//  Revision : 1.0 - initial release
// ============================================================================
module simdnx_round_sat #(
    parameter int CHANNELS     = 4,
    parameter int INPUT_WIDTH  = 48,
    parameter int OUTPUT_WIDTH = 9,
    parameter int SHIFT_WIDTH  = 4,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             aresetn,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [CHANNELS*INPUT_WIDTH-1:0]  s_data,
    input  logic [SHIFT_WIDTH-1:0]           s_shift,
    input  logic [1:0]                       s_mode,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [CHANNELS*OUTPUT_WIDTH-1:0] m_data,
    output logic [CHANNELS-1:0]              m_sat,
    input  logic                             sat_clr,
    output logic [CNT_WIDTH-1:0]             sat_count
);

    // Rounded intermediates carry one extra bit so the +1 never wraps.
    localparam int c_rw = INPUT_WIDTH + 1;

    localparam logic [1:0] c_mode_trunc = 2'b01;
    localparam logic [1:0] c_mode_even  = 2'b10;

    // Clip limits expressed at intermediate width.
    localparam logic signed [c_rw-1:0] c_sat_max =
        {{(c_rw-OUTPUT_WIDTH+1){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
    localparam logic signed [c_rw-1:0] c_sat_min =
        {{(c_rw-OUTPUT_WIDTH+1){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

    logic                            w_en;

    logic                            r_s1_valid;
    logic [CHANNELS*INPUT_WIDTH-1:0] r_s1_data;
    logic [SHIFT_WIDTH-1:0]          r_s1_shift;
    logic [1:0]                      r_s1_mode;

    logic                            r_s2_valid;
    logic [CHANNELS*c_rw-1:0]        r_s2_data;

    logic [CHANNELS*c_rw-1:0]         w_rnd_data;
    logic [CHANNELS*OUTPUT_WIDTH-1:0] w_sat_data;
    logic [CHANNELS-1:0]              w_sat_flag;

    logic                             r_m_valid;
    logic [CHANNELS*OUTPUT_WIDTH-1:0] r_m_data;
    logic [CHANNELS-1:0]              r_m_sat;
    logic [CNT_WIDTH-1:0]             r_sat_count;

    // The whole pipe moves together; a held output freezes every stage.
    assign w_en      = !r_m_valid || m_ready;
    assign s_ready   = w_en;
    assign m_valid   = r_m_valid;
    assign m_data    = r_m_data;
    assign m_sat     = r_m_sat;
    assign sat_count = r_sat_count;

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
        logic signed [c_rw-1:0] w_x;
        logic signed [c_rw-1:0] w_shifted;
        logic signed [c_rw-1:0] w_rnd;
        logic [c_rw-1:0]        w_lowmask;
        logic [c_rw-1:0]        w_halfbit;
        logic                   w_guard;
        logic                   w_sticky;
        logic                   w_inc;
        logic signed [c_rw-1:0] w_s2;
        logic [OUTPUT_WIDTH-1:0] w_clip;
        logic                   w_clipped;

        // Shift, then decide the rounding increment from guard/sticky bits.
        always_comb begin
            w_x       = {r_s1_data[gi*INPUT_WIDTH+INPUT_WIDTH-1],
                         r_s1_data[gi*INPUT_WIDTH +: INPUT_WIDTH]};
            w_shifted = w_x >>> r_s1_shift;
            // Ones in the bits dropped by the shift; the top one is the guard.
            w_lowmask = ~({c_rw{1'b1}} << r_s1_shift);
            w_halfbit = w_lowmask & ~(w_lowmask >> 1);
            w_guard   = |(w_x & w_halfbit);
            w_sticky  = |(w_x & (w_lowmask >> 1));
            case (r_s1_mode)
                c_mode_trunc: w_inc = 1'b0;
                c_mode_even:  w_inc = w_guard && (w_sticky || w_shifted[0]);
                default:      w_inc = w_guard;
            endcase
            w_rnd = w_shifted + {{(c_rw-1){1'b0}}, w_inc};
        end

        assign w_rnd_data[gi*c_rw +: c_rw] = w_rnd;

        // Clip the rounded value into the signed output range.
        always_comb begin
            w_s2 = r_s2_data[gi*c_rw +: c_rw];
            if (w_s2 > c_sat_max) begin
                w_clip    = c_sat_max[OUTPUT_WIDTH-1:0];
                w_clipped = 1'b1;
            end else if (w_s2 < c_sat_min) begin
                w_clip    = c_sat_min[OUTPUT_WIDTH-1:0];
                w_clipped = 1'b1;
            end else begin
                w_clip    = w_s2[OUTPUT_WIDTH-1:0];
                w_clipped = 1'b0;
            end
        end

        assign w_sat_data[gi*OUTPUT_WIDTH +: OUTPUT_WIDTH] = w_clip;
        assign w_sat_flag[gi]                              = w_clipped;
    end

    // Stage valid bits: reset flushes every beat in flight.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (w_en) begin
            r_s1_valid <= s_valid;
            r_s2_valid <= r_s1_valid;
        end
    end

    // Stage payloads; shift and mode travel with their beat.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_s1_data  <= s_data;
            r_s1_shift <= s_shift;
            r_s1_mode  <= s_mode;
            r_s2_data  <= w_rnd_data;
        end
    end

    // Output stage, cleared on reset so idle outputs read as zero.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= '0;
        end else if (w_en) begin
            r_m_valid <= r_s2_valid;
            r_m_data  <= w_sat_data;
            r_m_sat   <= r_s2_valid ? w_sat_flag : '0;
        end
    end

    // Saturating count of clipped beats; a clear wins over an increment.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_sat_count <= '0;
        end else if (sat_clr) begin
            r_sat_count <= '0;
        end else if (w_en && r_s2_valid && (|w_sat_flag) && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
